// File: rtl/ti_lut_share_pipe.sv
// ti_lut_share_pipe: loadable TI share truth table evaluated through a two-register glitch-barrier pipeline
module ti_lut_share_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_we,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             load_done,
  output logic             err
);
  localparam int DEPTH = 1 << IN_W;
  localparam logic [IN_W:0] FULL = (IN_W+1)'(DEPTH);
  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
  state_t state;
  logic [IN_W-1:0] ptr, wa, s1_a;
  logic [IN_W:0] cnt, cnt_nx;
  logic [OUT_W-1:0] tbl [DEPTH];
  logic wr, bad, acc, s1_v;
  // write decode: a restart in the same cycle rewinds the pointer before the write lands
  always_comb begin
    wr = cfg_we && (state == LOAD || (state == EMPTY && cfg_start));
    wa = cfg_start ? '0 : ptr;
    cnt_nx = (cfg_start ? '0 : cnt) + (IN_W+1)'(wr);
    acc = in_valid && state == RUN;
    bad = (cfg_we && state == EMPTY && !cfg_start) || ((cfg_we || cfg_start) && state == RUN) || (in_valid && state != RUN);
  end
  // load FSM with registered load_done and sticky err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= '0;
      cnt <= '0;
      load_done <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= err | bad;
      if (state != RUN && (cfg_start || wr)) begin
        ptr <= wa + IN_W'(wr);
        cnt <= cnt_nx;
      end
      if (state != RUN && cfg_start) state <= LOAD;
      if (wr && cnt_nx == FULL) begin
        state <= RUN;
        load_done <= 1'b1;
      end
    end
  end
  // truth table storage, frozen once loading completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr) begin
      tbl[wa] <= cfg_data;
    end
  end
  // two-register lookup: address then result, so no combinational path from in to out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      out_valid <= 1'b0;
      out <= '0;
    end else begin
      s1_v <= acc;
      if (acc) s1_a <= in;
      out_valid <= s1_v;
      if (s1_v) out <= tbl[s1_a];
    end
  end
endmodule

// File: tb/tb_ti_lut_share_pipe.sv
// tb_ti_lut_share_pipe: randomized self-checking bench against a table/queue reference model
module tb_ti_lut_share_pipe;
  logic clk = 0, rst_n = 0, cfg_start = 0, cfg_we = 0, in_valid = 0;
  logic [3:0] cfg_data = 0;
  logic [7:0] in_d = 0;
  logic out_valid, load_done, err;
  logic [3:0] out;
  int total = 0, bad = 0;
  logic [3:0] mtbl [256];
  logic [3:0] mout;
  int mptr;

  ti_lut_share_pipe #(.IN_W(8), .OUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_data(cfg_data),
    .in_valid(in_valid), .in(in_d), .out_valid(out_valid), .out(out), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mtbl[i] = 4'h0;
    mout = 4'h0;
    mptr = 0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 0;
    cfg_start = 0;
    cfg_we = 0;
    in_valid = 0;
    model_clear();
    repeat (2) cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic write_cfg(input logic st, input logic we, input logic [3:0] d);
    cfg_start = st;
    cfg_we = we;
    cfg_data = d;
    cyc();
    cfg_start = 0;
    cfg_we = 0;
    if (st) mptr = 0;
    if (we) begin
      mtbl[mptr % 256] = d;
      mptr++;
    end
  endtask

  task automatic test_stream(input int mode, input int n);
    bit vh[$];
    logic [7:0] ah[$];
    bit v;
    logic [7:0] a;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        a = (mode == 0) ? 8'(i) : 8'($urandom_range(255));
        v = (mode == 2) ? (i % 2 == 0) : (mode == 3) ? bit'($urandom_range(1)) : 1'b1;
        in_valid = v;
        in_d = a;
        vh.push_back(v);
        ah.push_back(a);
      end else begin
        in_valid = 0;
      end
      cyc();
      total++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL stream%0d_latency: out_valid=%b want 0", mode, out_valid);
        end
      end else begin
        if (vh[i-1]) mout = mtbl[ah[i-1]];
        if (out_valid !== vh[i-1] || out !== mout) begin
          bad++;
          $display("FAIL stream%0d[%0d] in=%h: out_valid=%b out=%h want %b %h", mode, i-1, ah[i-1], out_valid, out, vh[i-1], mout);
        end
      end
    end
    cyc();
    total++;
    if (out_valid !== 1'b0 || out !== mout) begin
      bad++;
      $display("FAIL stream%0d_drain: out_valid=%b out=%h want 0 %h", mode, out_valid, out, mout);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out !== 4'h0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
    if (load_done !== 1'b0) begin bad++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_load_xor();
    logic [7:0] av;
    write_cfg(1, 0, 0);
    for (int k = 0; k < 256; k++) begin
      av = 8'(k);
      write_cfg(0, 1, av[3:0] ^ av[7:4]);
      total++;
      if (load_done !== (k == 255)) begin
        bad++;
        $display("FAIL xor_load_done after write %0d: got %b want %b", k+1, load_done, k == 255);
      end
    end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL xor_err: got %b want 0", err); end
    test_stream(0, 256);
  endtask

  task automatic test_async_reset();
    in_valid = 1;
    in_d = 8'hA5;
    cyc();
    cyc();
    total++;
    if (out_valid !== 1'b1 || out !== 4'hF) begin
      bad++;
      $display("FAIL async_pre: out_valid=%b out=%h want 1 f", out_valid, out);
    end
    #2;
    rst_n = 0;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
    if (out !== 4'h0) begin bad++; $display("FAIL async_out: got %h want 0", out); end
    if (load_done !== 1'b0) begin bad++; $display("FAIL async_load_done: got %b want 0", load_done); end
    if (err !== 1'b0) begin bad++; $display("FAIL async_err: got %b want 0", err); end
    in_valid = 0;
    model_clear();
    cyc();
    rst_n = 1;
    cyc();
    in_valid = 1;
    in_d = 8'h12;
    cyc();
    in_valid = 0;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL async_post_err: got %b want 1", err); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL async_post_drop[%0d]: out_valid=%b want 0", k, out_valid); end
    end
  endtask

  task automatic test_restart();
    do_reset();
    write_cfg(1, 0, 0);
    for (int k = 0; k < 100; k++) begin
      write_cfg(0, 1, 4'hF);
      total++;
      if (load_done !== 1'b0) begin bad++; $display("FAIL restart_pre[%0d]: load_done=%b want 0", k, load_done); end
    end
    write_cfg(1, 0, 0);
    for (int k = 0; k < 256; k++) begin
      write_cfg(0, 1, 4'h3);
      total++;
      if (load_done !== (k == 255)) begin
        bad++;
        $display("FAIL restart_load_done after write %0d: got %b want %b", k+1, load_done, k == 255);
      end
    end
    test_stream(1, 64);
  endtask

  task automatic test_combined();
    do_reset();
    write_cfg(1, 0, 0);
    for (int k = 0; k < 10; k++) write_cfg(0, 1, 4'h5);
    write_cfg(1, 1, 4'h9);
    for (int k = 0; k < 255; k++) begin
      write_cfg(0, 1, 4'h0);
      total++;
      if (load_done !== (k == 254)) begin
        bad++;
        $display("FAIL combined_load_done after write %0d: got %b want %b", k+1, load_done, k == 254);
      end
    end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL combined_err: got %b want 0", err); end
    test_stream(0, 4);
  endtask

  task automatic test_run_errors();
    cfg_we = 1;
    cfg_data = 4'h0;
    cyc();
    cfg_we = 0;
    total += 2;
    if (err !== 1'b1) begin bad++; $display("FAIL run_we_err: got %b want 1", err); end
    if (load_done !== 1'b1) begin bad++; $display("FAIL run_we_load_done: got %b want 1", load_done); end
    cfg_start = 1;
    cyc();
    cfg_start = 0;
    total++;
    if (load_done !== 1'b1) begin bad++; $display("FAIL run_start_load_done: got %b want 1", load_done); end
    test_stream(0, 3);
  endtask

  task automatic test_early_input();
    do_reset();
    write_cfg(1, 0, 0);
    for (int k = 0; k < 5; k++) write_cfg(0, 1, 4'(k + 1));
    in_valid = 1;
    in_d = 8'h03;
    cyc();
    in_valid = 0;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL early_err: got %b want 1", err); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL early_drop[%0d]: out_valid=%b want 0", k, out_valid); end
    end
    for (int k = 5; k < 255; k++) write_cfg(0, 1, 4'($urandom_range(15)));
    in_valid = 1;
    in_d = 8'h01;
    write_cfg(0, 1, 4'hC);
    in_valid = 0;
    total++;
    if (load_done !== 1'b1) begin bad++; $display("FAIL final_write_load_done: got %b want 1", load_done); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL final_write_drop[%0d]: out_valid=%b want 0", k, out_valid); end
    end
    test_stream(1, 32);
  endtask

  initial begin
    test_reset();
    test_load_xor();
    test_stream(2, 40);
    test_stream(3, 60);
    test_async_reset();
    test_restart();
    test_combined();
    test_run_errors();
    test_early_input();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
